// File: rtl/memory_access.sv
// Memory stage of the 5-stage MIPS pipeline: req/ack data-bus access, stall generation, MEM/WB register.
// Optional feature macro MEM_TIMEOUT_EN: abort a BUSY access after TIMEOUT cycles without ack.
module memory_access #(
    parameter int TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_nrst,
    input  logic [31:0] i_data_pc4,
    input  logic [31:0] i_data_alures,
    input  logic [31:0] i_data_rt,
    input  logic [4:0]  i_addr_regdst,
    input  logic        i_con_Mmemread,
    input  logic        i_con_Mmemwrite,
    input  logic        i_con_Malupc8,
    input  logic        i_con_Wmemtoreg,
    input  logic        i_con_Wregwrite,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_con_stall,
    output logic [31:0] o_data_FMalures,
    output logic [4:0]  o_addr_Mregdst,
    output logic        o_con_Mregwrite,
    output logic [31:0] o_data_wbres,
    output logic [4:0]  o_addr_regdst,
    output logic        o_con_Wregwrite,
    output logic        o_err_timeout,
    output logic        o_dbg_state
);
    // Bus handshake: o_mem_req rises on the edge leaving IDLE and holds we/addr/wdata stable
    // until a cycle with i_mem_ack high; that cycle completes the transfer (read data sampled
    // in it) and req falls on the following edge. Ack seen while req is low is ignored.

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] wbres_q, wbres_d;
    logic [4:0]  regdst_q, regdst_d;
    logic        wregwrite_q, wregwrite_d;

    logic        access;
    logic        bubble;
    logic        stall;
    logic [31:0] fwd;
    logic [31:0] memdata;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("memory_access: TIMEOUT must be at least 1");
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT) + 1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`endif

    assign access  = i_con_Mmemread | i_con_Mmemwrite;
    assign fwd     = i_con_Malupc8 ? (i_data_pc4 + 32'd4) : i_data_alures;
    // Load data bypasses the capture register in the ack cycle itself.
    assign memdata = ((state_q == BUSY) && i_mem_ack) ? i_mem_rdata : rdata_q;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        stall   = 1'b0;
        bubble  = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (access) begin
                    state_d = BUSY;
                    req_d   = 1'b1;
                    we_d    = i_con_Mmemwrite;
                    addr_d  = i_data_alures;
                    wdata_d = i_data_rt;
                    stall   = 1'b1;
                    bubble  = 1'b1;
`ifdef MEM_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            BUSY: begin
                if (i_mem_ack) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    if (!we_q) begin
                        rdata_d = i_mem_rdata;
                    end
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    // Abandon the access; the instruction retires without writing back.
                    state_d = IDLE;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    bubble  = 1'b1;
                end
`endif
                else begin
                    stall  = 1'b1;
                    bubble = 1'b1;
`ifdef MEM_TIMEOUT_EN
                    cnt_d  = cnt_q + CW'(1);
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        wbres_d     = i_con_Wmemtoreg ? memdata : fwd;
        regdst_d    = i_addr_regdst;
        wregwrite_d = i_con_Wregwrite & ~bubble;
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            wbres_q     <= '0;
            regdst_q    <= '0;
            wregwrite_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            wbres_q     <= wbres_d;
            regdst_q    <= regdst_d;
            wregwrite_q <= wregwrite_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    assign o_mem_req       = req_q;
    assign o_mem_we        = we_q;
    assign o_mem_addr      = addr_q;
    assign o_mem_wdata     = wdata_q;
    assign o_con_stall     = stall;
    assign o_data_FMalures = fwd;
    assign o_addr_Mregdst  = i_addr_regdst;
    assign o_con_Mregwrite = i_con_Wregwrite;
    assign o_data_wbres    = wbres_q;
    assign o_addr_regdst   = regdst_q;
    assign o_con_Wregwrite = wregwrite_q;
    assign o_dbg_state     = state_q;
`ifdef MEM_TIMEOUT_EN
    assign o_err_timeout   = err_q;
`else
    assign o_err_timeout   = 1'b0;
`endif

endmodule
